// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel front end: input pixel formats and the
// default Q0.8 luma weights used by gray_pipe.
package sobel_pkg;

  localparam int IN_FMT_RGB565 = 0;
  localparam int IN_FMT_RGB888 = 1;

  localparam int LUMA_COEF_R = 77;
  localparam int LUMA_COEF_G = 150;
  localparam int LUMA_COEF_B = 29;

  // Half an LSB of the Q0.8 result, so the >>8 rounds to nearest.
  localparam int LUMA_RND = 128;

endpackage

// File: rtl/gray_minmax.sv
// Per-frame min/max luma tracker: latches the previous frame's extremes
// on each accepted sof beat and pulses stat_flag for one cycle.
module gray_minmax (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       beat,
  input  logic       sof,
  input  logic [7:0] luma,
  output logic [7:0] stat_min,
  output logic [7:0] stat_max,
  output logic       stat_flag
);

  logic [7:0] run_min;
  logic [7:0] run_max;
  logic       seen_sof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_min   <= 8'hFF;
      run_max   <= 8'h00;
      seen_sof  <= 1'b0;
      stat_min  <= 8'hFF;
      stat_max  <= 8'h00;
      stat_flag <= 1'b0;
    end else begin
      stat_flag <= 1'b0;
      if (beat) begin
        if (sof) begin
          // The very first sof has no complete prior frame to report.
          if (seen_sof) begin
            stat_min  <= run_min;
            stat_max  <= run_max;
            stat_flag <= 1'b1;
          end
          seen_sof <= 1'b1;
          run_min  <= luma;
          run_max  <= luma;
        end else begin
          if (luma < run_min) run_min <= luma;
          if (luma > run_max) run_max <= luma;
        end
      end
    end
  end

endmodule

// File: rtl/gray_pipe.sv
// Three-stage RGB565/RGB888 to luma converter with valid/ready flow control.
// Optional per-frame min/max statistics are built when GRAY_STATS_EN is defined.
module gray_pipe
  import sobel_pkg::*;
#(
  parameter int IN_FMT = IN_FMT_RGB565,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 8,
  parameter int COEF_R = LUMA_COEF_R,
  parameter int COEF_G = LUMA_COEF_G,
  parameter int COEF_B = LUMA_COEF_B
) (
  input  logic             tft_clk,
  input  logic             tft_rst,
  input  logic [IN_W-1:0]  gray_ip_data,
  input  logic             gray_ip_flag,
  input  logic             gray_ip_sof,
  input  logic             gray_ip_eol,
  output logic             gray_ip_ready,
  output logic [OUT_W-1:0] gray_op_data,
  output logic             gray_op_flag,
  output logic             gray_op_sof,
  output logic             gray_op_eol,
`ifdef GRAY_STATS_EN
  output logic [7:0]       gray_stat_min,
  output logic [7:0]       gray_stat_max,
  output logic             gray_stat_flag,
`endif
  input  logic             gray_op_ready
);

  // Handshake: a beat moves on a port when its flag and ready are both high
  // at a rising edge. The whole pipe advances as one on ce, which is high
  // whenever the output register is empty or being drained this cycle.
  logic ce;
  assign ce            = ~gray_op_flag | gray_op_ready;
  assign gray_ip_ready = ce;

  logic [7:0] r_in;
  logic [7:0] g_in;
  logic [7:0] b_in;

  if (IN_FMT == IN_FMT_RGB888) begin : g_rgb888
    assign r_in = gray_ip_data[23:16];
    assign g_in = gray_ip_data[15:8];
    assign b_in = gray_ip_data[7:0];
  end else begin : g_rgb565
    // MSB replication maps full-scale 5/6-bit codes onto 8'hFF exactly.
    assign r_in = {gray_ip_data[15:11], gray_ip_data[15:13]};
    assign g_in = {gray_ip_data[10:5],  gray_ip_data[10:9]};
    assign b_in = {gray_ip_data[4:0],   gray_ip_data[4:2]};
  end

  logic        s1_valid, s1_sof, s1_eol;
  logic [7:0]  s1_r, s1_g, s1_b;
  logic        s2_valid, s2_sof, s2_eol;
  logic [15:0] s2_pr, s2_pg, s2_pb;

  logic [17:0] sum;
  logic [9:0]  y_wide;
  logic [7:0]  y8;

  assign sum    = 18'(s2_pr) + 18'(s2_pg) + 18'(s2_pb) + 18'(LUMA_RND);
  assign y_wide = 10'(sum >> 8);
  assign y8     = (y_wide > 10'd255) ? 8'hFF : y_wide[7:0];

  always_ff @(posedge tft_clk or negedge tft_rst) begin
    if (!tft_rst) begin
      s1_valid     <= 1'b0;
      s1_sof       <= 1'b0;
      s1_eol       <= 1'b0;
      s1_r         <= 8'h00;
      s1_g         <= 8'h00;
      s1_b         <= 8'h00;
      s2_valid     <= 1'b0;
      s2_sof       <= 1'b0;
      s2_eol       <= 1'b0;
      s2_pr        <= 16'h0000;
      s2_pg        <= 16'h0000;
      s2_pb        <= 16'h0000;
      gray_op_flag <= 1'b0;
      gray_op_sof  <= 1'b0;
      gray_op_eol  <= 1'b0;
      gray_op_data <= '0;
    end else if (ce) begin
      // Markers are masked by valid so empty stages never carry sof/eol.
      s1_valid     <= gray_ip_flag;
      s1_sof       <= gray_ip_flag & gray_ip_sof;
      s1_eol       <= gray_ip_flag & gray_ip_eol;
      s1_r         <= r_in;
      s1_g         <= g_in;
      s1_b         <= b_in;

      s2_valid     <= s1_valid;
      s2_sof       <= s1_sof;
      s2_eol       <= s1_eol;
      s2_pr        <= 16'(s1_r) * 16'(COEF_R);
      s2_pg        <= 16'(s1_g) * 16'(COEF_G);
      s2_pb        <= 16'(s1_b) * 16'(COEF_B);

      gray_op_flag <= s2_valid;
      gray_op_sof  <= s2_sof;
      gray_op_eol  <= s2_eol;
      gray_op_data <= OUT_W'(y8 >> (8 - OUT_W));
    end
  end

`ifdef GRAY_STATS_EN
  // Statistics are kept on the 8-bit scale regardless of OUT_W.
  logic [7:0] stat_luma;
  assign stat_luma = 8'(8'(gray_op_data) << (8 - OUT_W));

  gray_minmax u_minmax (
    .clk       (tft_clk),
    .rst_n     (tft_rst),
    .beat      (gray_op_flag & gray_op_ready),
    .sof       (gray_op_sof),
    .luma      (stat_luma),
    .stat_min  (gray_stat_min),
    .stat_max  (gray_stat_max),
    .stat_flag (gray_stat_flag)
  );
`endif

endmodule

// File: tb/tb_gray_pipe.sv
// Bench for gray_pipe: RGB565/8-bit, RGB888/8-bit and RGB565/4-bit instances,
// directed latency vectors, a stalled random stream and async reset recovery.
`timescale 1ns/1ps
module tb_gray_pipe;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT A: RGB565, OUT_W=8 ----------------
  logic [15:0] a_ip_data = '0;
  logic        a_ip_flag = 0, a_ip_sof = 0, a_ip_eol = 0, a_ip_ready;
  logic [7:0]  a_op_data;
  logic        a_op_flag, a_op_sof, a_op_eol, a_op_ready = 1;
`ifdef GRAY_STATS_EN
  logic [7:0]  a_stat_min, a_stat_max;
  logic        a_stat_flag;
`endif

  gray_pipe #(.IN_FMT(0), .IN_W(16), .OUT_W(8)) dut_a (
    .tft_clk(clk), .tft_rst(rst_n),
    .gray_ip_data(a_ip_data), .gray_ip_flag(a_ip_flag),
    .gray_ip_sof(a_ip_sof), .gray_ip_eol(a_ip_eol), .gray_ip_ready(a_ip_ready),
    .gray_op_data(a_op_data), .gray_op_flag(a_op_flag),
    .gray_op_sof(a_op_sof), .gray_op_eol(a_op_eol),
`ifdef GRAY_STATS_EN
    .gray_stat_min(a_stat_min), .gray_stat_max(a_stat_max), .gray_stat_flag(a_stat_flag),
`endif
    .gray_op_ready(a_op_ready)
  );

  // ---------------- DUT B: RGB888, OUT_W=8 ----------------
  logic [23:0] b_ip_data = '0;
  logic        b_ip_flag = 0, b_ip_sof = 0, b_ip_eol = 0, b_ip_ready;
  logic [7:0]  b_op_data;
  logic        b_op_flag, b_op_sof, b_op_eol, b_op_ready = 1;
`ifdef GRAY_STATS_EN
  logic [7:0]  b_stat_min, b_stat_max;
  logic        b_stat_flag;
`endif

  gray_pipe #(.IN_FMT(1), .IN_W(24), .OUT_W(8)) dut_b (
    .tft_clk(clk), .tft_rst(rst_n),
    .gray_ip_data(b_ip_data), .gray_ip_flag(b_ip_flag),
    .gray_ip_sof(b_ip_sof), .gray_ip_eol(b_ip_eol), .gray_ip_ready(b_ip_ready),
    .gray_op_data(b_op_data), .gray_op_flag(b_op_flag),
    .gray_op_sof(b_op_sof), .gray_op_eol(b_op_eol),
`ifdef GRAY_STATS_EN
    .gray_stat_min(b_stat_min), .gray_stat_max(b_stat_max), .gray_stat_flag(b_stat_flag),
`endif
    .gray_op_ready(b_op_ready)
  );

  // ---------------- DUT C: RGB565, OUT_W=4 ----------------
  logic [15:0] c_ip_data = '0;
  logic        c_ip_flag = 0, c_ip_sof = 0, c_ip_eol = 0, c_ip_ready;
  logic [3:0]  c_op_data;
  logic        c_op_flag, c_op_sof, c_op_eol, c_op_ready = 1;
`ifdef GRAY_STATS_EN
  logic [7:0]  c_stat_min, c_stat_max;
  logic        c_stat_flag;
`endif

  gray_pipe #(.IN_FMT(0), .IN_W(16), .OUT_W(4)) dut_c (
    .tft_clk(clk), .tft_rst(rst_n),
    .gray_ip_data(c_ip_data), .gray_ip_flag(c_ip_flag),
    .gray_ip_sof(c_ip_sof), .gray_ip_eol(c_ip_eol), .gray_ip_ready(c_ip_ready),
    .gray_op_data(c_op_data), .gray_op_flag(c_op_flag),
    .gray_op_sof(c_op_sof), .gray_op_eol(c_op_eol),
`ifdef GRAY_STATS_EN
    .gray_stat_min(c_stat_min), .gray_stat_max(c_stat_max), .gray_stat_flag(c_stat_flag),
`endif
    .gray_op_ready(c_op_ready)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] luma_rgb(input int r8, input int g8, input int b8);
    int y;
    y = (r8 * 77 + g8 * 150 + b8 * 29 + 128) / 256;
    if (y > 255) y = 255;
    return y[7:0];
  endfunction

  function automatic logic [7:0] luma565(input logic [15:0] p);
    int r5, g6, b5;
    r5 = int'(p[15:11]);
    g6 = int'(p[10:5]);
    b5 = int'(p[4:0]);
    return luma_rgb(r5 * 8 + r5 / 4, g6 * 4 + g6 / 16, b5 * 8 + b5 / 4);
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic directed(input logic [15:0] p565, input logic [7:0] e565,
                          input logic [23:0] p888, input logic [7:0] e888,
                          input logic [3:0]  e4);
    int lat;
    @(negedge clk);
    a_op_ready = 1; b_op_ready = 1; c_op_ready = 1;
    #1;
    check("dir_ip_ready", a_ip_ready, 1);
    a_ip_data = p565; a_ip_flag = 1;
    b_ip_data = p888; b_ip_flag = 1;
    c_ip_data = p565; c_ip_flag = 1;
    for (lat = 1; lat <= 8; lat++) begin
      @(negedge clk);
      a_ip_flag = 0; b_ip_flag = 0; c_ip_flag = 0;
      if (a_op_flag) break;
    end
    check("dir_latency", lat, 3);
    check("dir_565_data", a_op_data, e565);
    check("dir_888_flag", b_op_flag, 1);
    check("dir_888_data", b_op_data, e888);
    check("dir_w4_data", c_op_data, e4);
  endtask

  // ---------------- stimulus ----------------
  localparam int N_BEATS = 56;
  logic [15:0] pix [N_BEATS];

  initial begin
    int sent, recv, cyc, pulses;
    bit prev_stall;
    logic [9:0] prev_out, exp_v;
    logic [7:0] pmin, pmax;

    // Reset state, before any clock edge.
    #1;
    check("rst_op_flag", a_op_flag, 0);
    check("rst_op_data", a_op_data, 0);
    check("rst_op_sof_eol", {a_op_sof, a_op_eol}, 0);
    check("rst_ip_ready", a_ip_ready, 1);
`ifdef GRAY_STATS_EN
    check("rst_stat_min", a_stat_min, 8'hFF);
    check("rst_stat_max", a_stat_max, 8'h00);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // Directed vectors.
    directed(16'hFFFF, 8'd255, 24'h808080, 8'd128, 4'hF);
    directed(16'h0000, 8'd0,   24'hFF0000, 8'd77,  4'h0);
    directed(16'hF800, 8'd77,  24'h00FF00, 8'd149, 4'h4);
    directed(16'h07E0, 8'd149, 24'h0000FF, 8'd29,  4'h9);
    directed(16'h001F, 8'd29,  24'hFFFFFF, 8'd255, 4'h1);

    // Stream: 16 ramp pixels then random, with output backpressure.
    for (int i = 0; i < N_BEATS; i++)
      pix[i] = (i < 16) ? 16'(i * 16'h1041) : 16'($urandom_range(0, 65535));
    sent = 0; recv = 0; cyc = 0; prev_stall = 0; prev_out = '0;
    while ((sent < N_BEATS || exp_q.size() > 0) && cyc < 2000) begin
      @(negedge clk);
      if (cyc < 40) a_op_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      else          a_op_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        check("hold_flag", a_op_flag, 1);
        check("hold_data", {a_op_sof, a_op_eol, a_op_data}, prev_out);
      end
      check("ip_ready_stall", a_ip_ready, !(a_op_flag && !a_op_ready));
      if (a_op_flag && a_op_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", a_op_flag, 0);
        end else begin
          exp_v = exp_q.pop_front();
          check("stream_beat", {a_op_sof, a_op_eol, a_op_data}, exp_v);
          recv++;
        end
      end
      prev_stall = a_op_flag && !a_op_ready;
      prev_out   = {a_op_sof, a_op_eol, a_op_data};
      if (sent < N_BEATS && (sent < 16 || $urandom_range(0, 3) != 0)) begin
        a_ip_flag = 1;
        a_ip_data = pix[sent];
        a_ip_sof  = (sent == 0);
        a_ip_eol  = (sent == 7);
      end else begin
        a_ip_flag = 0;
        a_ip_data = 16'($urandom_range(0, 65535));
        a_ip_sof  = 0;
        a_ip_eol  = 0;
      end
      if (a_ip_flag && a_ip_ready) begin
        exp_q.push_back({a_ip_sof, a_ip_eol, luma565(a_ip_data)});
        sent++;
      end
      cyc++;
    end
    check("stream_recv_count", recv, N_BEATS);
    check("stream_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    a_ip_flag = 0; a_ip_sof = 0; a_ip_eol = 0; a_op_ready = 1;

    // Async reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_ip_flag = 1; a_ip_data = 16'hFFFF; a_ip_sof = 1; a_ip_eol = 1;
    end
    @(negedge clk);
    a_ip_flag = 0; a_ip_sof = 0; a_ip_eol = 0;
    #1;
    check("inflight_flag", a_op_flag, 1);
    #1;
    rst_n = 0;
    #1;
    check("async_rst_flag", a_op_flag, 0);
    check("async_rst_data", a_op_data, 0);
    check("async_rst_sof_eol", {a_op_sof, a_op_eol}, 0);
    @(negedge clk);
    rst_n = 1;
`ifdef GRAY_STATS_EN
    check("rerst_stat_min", a_stat_min, 8'hFF);
    check("rerst_stat_max", a_stat_max, 8'h00);
`endif
    directed(16'hFFFF, 8'd255, 24'hFFFFFF, 8'd255, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_beat", a_op_flag, 0);
    end

`ifdef GRAY_STATS_EN
    // Frame {0000, FFFF, F800} then the next sof.
    pulses = 0; pmin = '0; pmax = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (a_stat_flag) begin
        pulses++;
        pmin = a_stat_min;
        pmax = a_stat_max;
      end
      a_ip_flag = (i < 4);
      a_ip_sof  = (i == 0) || (i == 3);
      a_ip_eol  = 0;
      case (i)
        0:       a_ip_data = 16'h0000;
        1:       a_ip_data = 16'hFFFF;
        2:       a_ip_data = 16'hF800;
        default: a_ip_data = 16'h07E0;
      endcase
    end
    check("stat_pulse_count", pulses, 1);
    check("stat_min", pmin, 8'd0);
    check("stat_max", pmax, 8'd255);
`else
    pulses = 0; pmin = '0; pmax = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
